// File: rtl/shift_reg_seq.sv
// Sequencer that drives mode/load_data/serial_out of an external shift register.
// Optional active-cycle counter on pwr_cnt is built only when SHIFT_SEQ_PWR_CNT_EN is defined.
module shift_reg_seq #(
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              ENB_L,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [2:0]        req_count,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_serial,
  input  logic              abort,
  output logic              req_ready,
  output logic [1:0]        mode,
  output logic [DATA_W-1:0] load_data,
  output logic              serial_out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pwr_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [2:0]        rem;
  logic [2:0]        rem_nxt;
  logic [1:0]        op_q;
  logic [1:0]        op_nxt;
  logic [1:0]        mode_nxt;
  logic [DATA_W-1:0] load_data_nxt;
  logic              serial_nxt;
  logic              accept;

  assign req_ready = (state == IDLE) & ~abort;
  assign accept    = req_valid & req_ready;
  assign op_nxt    = accept ? req_op : op_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_op == OP_LOAD)
            state_nxt = LOAD;
          else if ((req_op != OP_HOLD) && (req_count != 3'd0))
            state_nxt = SHIFT;
          else
            state_nxt = DONE;
        end
      end
      LOAD:    state_nxt = abort ? IDLE : DONE;
      SHIFT:   state_nxt = abort ? IDLE : ((rem == 3'd1) ? DONE : SHIFT);
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from the next state.
  // At the accept edge the captured fields come straight from the req_* inputs.
  always_comb begin
    mode_nxt      = OP_HOLD;
    load_data_nxt = load_data;
    serial_nxt    = serial_out;
    rem_nxt       = 3'd0;
    case (state_nxt)
      LOAD: begin
        mode_nxt      = OP_LOAD;
        load_data_nxt = accept ? req_data : load_data;
      end
      SHIFT: begin
        mode_nxt   = op_nxt;
        serial_nxt = accept ? req_serial : serial_out;
        rem_nxt    = accept ? req_count : (rem - 3'd1);
      end
      default: begin
        mode_nxt = OP_HOLD;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ENB_L) begin
    if (!ENB_L) begin
      state      <= IDLE;
      rem        <= 3'd0;
      op_q       <= OP_HOLD;
      mode       <= OP_HOLD;
      load_data  <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      op_q       <= op_nxt;
      mode       <= mode_nxt;
      load_data  <= load_data_nxt;
      serial_out <= serial_nxt;
      busy       <= (state_nxt == LOAD) || (state_nxt == SHIFT);
      done       <= (state_nxt == DONE);
    end
  end

`ifdef SHIFT_SEQ_PWR_CNT_EN
  logic [7:0] pwr_q;

  // Counts edges on which the register is being driven with a non-hold mode.
  always_ff @(posedge CLK or negedge ENB_L) begin
    if (!ENB_L)
      pwr_q <= 8'd0;
    else if ((mode != OP_HOLD) && (pwr_q != 8'hFF))
      pwr_q <= pwr_q + 8'd1;
  end

  assign pwr_cnt = pwr_q;
`else
  assign pwr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_shift_reg_seq.sv
// Randomized self-checking bench for shift_reg_seq; the reference model is a per-transaction
// timeline (active length, expected mode, captured data) with a saturating active-cycle tally.
module tb_shift_reg_seq;

  logic       CLK = 1'b0;
  logic       ENB_L;
  logic       req_valid;
  logic [1:0] req_op;
  logic [2:0] req_count;
  logic [3:0] req_data;
  logic       req_serial;
  logic       abort;
  logic       req_ready;
  logic [1:0] mode;
  logic [3:0] load_data;
  logic       serial_out;
  logic       busy;
  logic       done;
  logic [7:0] pwr_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_load;
  logic       exp_ser;
  logic [7:0] exp_pwr;

  shift_reg_seq #(.DATA_W(4)) dut (
    .CLK(CLK), .ENB_L(ENB_L), .req_valid(req_valid), .req_op(req_op),
    .req_count(req_count), .req_data(req_data), .req_serial(req_serial),
    .abort(abort), .req_ready(req_ready), .mode(mode), .load_data(load_data),
    .serial_out(serial_out), .busy(busy), .done(done), .pwr_cnt(pwr_cnt)
  );

  always #5 CLK = ~CLK;

  // Observation layout: {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt}
  task automatic bump_pwr();
`ifdef SHIFT_SEQ_PWR_CNT_EN
    if (exp_pwr != 8'hFF) exp_pwr = exp_pwr + 8'd1;
`endif
  endtask

  task automatic test_reset();
    logic [17:0] obs, expv;
    ENB_L = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_count = 3'd0;
    req_data = 4'h0; req_serial = 1'b0; abort = 1'b0;
    exp_load = 4'h0; exp_ser = 1'b0; exp_pwr = 8'd0;
    #2;
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    expv = {1'b1, 2'b00, 1'b0, 1'b0, exp_load, exp_ser, exp_pwr};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs, expv);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    ENB_L = 1'b1;
    @(negedge CLK);
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", obs, expv);
    end
  endtask

  // One full transaction; begins and ends at a negedge with the DUT idle.
  task automatic run_op(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                        input logic ser, input int abort_at, input logic abort_in_done);
    logic [17:0] obs, expv;
    int len;
    len = (op == 2'b11) ? 1 : (((op == 2'b00) || (cnt == 3'd0)) ? 0 : int'(cnt));
    req_valid = 1'b1; req_op = op; req_count = cnt; req_data = data; req_serial = ser;
    abort = 1'b0;
    #1;
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    expv = {1'b1, 2'b00, 1'b0, 1'b0, exp_load, exp_ser, exp_pwr};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL accept_idle op=%b cnt=%0d: got %h expected %h", op, cnt, obs, expv);
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_count = 3'($urandom);
    req_data = 4'($urandom); req_serial = 1'($urandom);
    if (op == 2'b11) exp_load = data;
    else if (len > 0) exp_ser = ser;
    for (int k = 1; k <= len; k++) begin
      @(negedge CLK);
      obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
      expv = {1'b0, op, 1'b1, 1'b0, exp_load, exp_ser, exp_pwr};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL active op=%b cycle=%0d: got %h expected %h", op, k, obs, expv);
      end
      if (k == abort_at) begin
        abort = 1'b1;
        @(posedge CLK);
        #1 abort = 1'b0;
        bump_pwr();
        @(negedge CLK);
        obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
        expv = {1'b1, 2'b00, 1'b0, 1'b0, exp_load, exp_ser, exp_pwr};
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL abort op=%b cycle=%0d: got %h expected %h", op, k, obs, expv);
        end
        return;
      end
      @(posedge CLK);
      bump_pwr();
    end
    @(negedge CLK);
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    expv = {1'b0, 2'b00, 1'b0, 1'b1, exp_load, exp_ser, exp_pwr};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL done_pulse op=%b cnt=%0d: got %h expected %h", op, cnt, obs, expv);
    end
    if (abort_in_done) abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
    @(negedge CLK);
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    expv = {1'b1, 2'b00, 1'b0, 1'b0, exp_load, exp_ser, exp_pwr};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL back_to_idle op=%b cnt=%0d: got %h expected %h", op, cnt, obs, expv);
    end
  endtask

  task automatic test_load();
    run_op(2'b11, 3'd0, 4'b1010, 1'b0, 0, 1'b0);
    run_op(2'b11, 3'd5, 4'b0110, 1'b1, 0, 1'b0);
  endtask

  task automatic test_shift();
    run_op(2'b01, 3'd3, 4'h0, 1'b1, 0, 1'b0);
    run_op(2'b10, 3'd1, 4'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_zero_count();
    run_op(2'b10, 3'd0, 4'hF, 1'b1, 0, 1'b0);
    run_op(2'b00, 3'd6, 4'hF, 1'b1, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_op(2'b10, 3'd7, 4'h0, 1'b1, 2, 1'b0);
    run_op(2'b11, 3'd0, 4'h5, 1'b0, 1, 1'b0);
    run_op(2'b01, 3'd2, 4'h0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_idle_abort();
    logic [17:0] obs, expv;
    req_valid = 1'b1; req_op = 2'b11; req_data = ~exp_load; abort = 1'b1;
    #1;
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    expv = {1'b0, 2'b00, 1'b0, 1'b0, exp_load, exp_ser, exp_pwr};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL idle_abort_ready: got %h expected %h", obs, expv);
    end
    @(posedge CLK);
    #1 req_valid = 1'b0; abort = 1'b0;
    @(negedge CLK);
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    expv = {1'b1, 2'b00, 1'b0, 1'b0, exp_load, exp_ser, exp_pwr};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL idle_abort_noaccept: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [17:0] obs, expv;
    req_valid = 1'b1; req_op = 2'b01; req_count = 3'd5; req_serial = 1'b1; abort = 1'b0;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    #2 ENB_L = 1'b0;
    #1;
    exp_load = 4'h0; exp_ser = 1'b0; exp_pwr = 8'd0;
    obs  = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
    expv = {1'b1, 2'b00, 1'b0, 1'b0, exp_load, exp_ser, exp_pwr};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", obs, expv);
    end
    @(posedge CLK);
    @(negedge CLK);
    ENB_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      obs = {req_ready, mode, busy, done, load_data, serial_out, pwr_cnt};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL post_reset_idle cycle=%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_pwr();
    run_op(2'b11, 3'd0, 4'h9, 1'b0, 0, 1'b0);
    run_op(2'b01, 3'd4, 4'h0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    int ab;
    for (int i = 0; i < 60; i++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_op(2'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), ab,
             1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      run_op(2'b10 - 2'(i % 2), 3'd7, 4'($urandom), 1'($urandom), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_zero_count();
    test_abort();
    test_idle_abort();
    test_reset_mid_shift();
    test_pwr();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
SHIFT_REG_SEQ -- requirements
Module: shift_reg_seq

Interface
REQ-001 Parameter DATA_W, default 4, width of the controlled shift register's parallel data.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 ENB_L  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_op  input  2  operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-006 req_count  input  3  number of shift cycles, 0..7; ignored for load and hold.
REQ-007 req_data  input  DATA_W  parallel value for load.
REQ-008 req_serial  input  1  serial bit to feed during shifts.
REQ-009 abort  input  1  cancels the operation in progress.
REQ-010 req_ready  output  1  controller can accept a request this cycle.
REQ-011 mode  output  2  register control: same encoding as req_op.
REQ-012 load_data  output  DATA_W  parallel data driven to the register.
REQ-013 serial_out  output  1  serial-in bit driven to the register.
REQ-014 busy  output  1  operation in progress.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 pwr_cnt  output  8  active-cycle counter (see Configuration).

Function
REQ-017 States SHALL be IDLE, LOAD, SHIFT, DONE; all outputs registered.
REQ-018 req_ready SHALL equal (state==IDLE) & ~abort; a request is accepted on a rising edge when req_valid & req_ready.
REQ-019 On acceptance, req_op, req_count, req_data and req_serial SHALL be captured; later changes to the req_* inputs have no effect.
REQ-020 IDLE -> LOAD for op 11; IDLE -> SHIFT for op 01/10 with count>=1; IDLE -> DONE for op 00 or count 0.
REQ-021 LOAD SHALL last exactly 1 cycle, with mode=11 and load_data=captured data, then go to DONE.
REQ-022 SHIFT SHALL last exactly count cycles, with mode=captured op and serial_out=captured serial; an internal remaining-count register decrements each cycle and the FSM goes to DONE when it reaches 1.
REQ-023 DONE SHALL last 1 cycle with done=1 and mode=00, then go to IDLE.
REQ-024 mode SHALL be 00 in IDLE and DONE; busy=1 in LOAD and SHIFT only.
REQ-025 First non-hold mode cycle SHALL be the cycle after acceptance (latency 1); done SHALL assert count+1 cycles after acceptance for shifts and 2 cycles after for loads.
REQ-026 abort=1 in LOAD or SHIFT SHALL force IDLE at the next edge, mode=00, no done pulse; abort in DONE SHALL be ignored (done still pulses).
REQ-027 abort and req_valid together in IDLE: abort wins, no acceptance.
REQ-028 load_data and serial_out SHALL hold their last driven values outside LOAD/SHIFT.

Reset
REQ-029 ENB_L low SHALL immediately force state=IDLE, mode=00, load_data=0, serial_out=0, busy=0, done=0, pwr_cnt=0, remaining count=0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no done pulse; req_ready=1 on the first edge after release.

Configuration
REQ-031 Macro SHIFT_SEQ_PWR_CNT_EN defined: pwr_cnt SHALL increment by 1 on every edge where mode!=00 and saturate at 255.
REQ-032 Macro undefined: pwr_cnt SHALL be constant 0 and no counter logic SHALL be present; all other behaviour is identical.

Verification
REQ-033 Reset release, req_valid=1, op=11, data=4'b1010 -> mode=11, load_data=1010 for 1 cycle, done pulse 2 cycles after acceptance, req_ready=0 until IDLE.
REQ-034 op=01, count=3, serial=1 -> mode=01 for exactly 3 cycles, serial_out=1, done at cycle 4, busy high cycles 1-3.
REQ-035 op=10, count=0 -> no shift cycles, done the cycle after acceptance, mode stays 00.
REQ-036 op=10, count=7, abort in the 2nd SHIFT cycle -> mode=00 and IDLE next edge, no done, req_ready=1.
REQ-037 ENB_L pulsed low during SHIFT (count=5) -> outputs are reset values asynchronously and there is no done pulse; with SHIFT_SEQ_PWR_CNT_EN, pwr_cnt=0 after reset.
REQ-038 With SHIFT_SEQ_PWR_CNT_EN, a load followed by a shift with count=4 -> pwr_cnt=5; without the macro, pwr_cnt=0 throughout.
